// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 max-pool window generator.
package pool_pkg;
  localparam int DATA_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0]   pix_t;
  typedef logic [2*DATA_WIDTH-1:0] pix_pair_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// Half-row buffer: stores {even col, odd col} pixel pairs of the even row.
// Synchronous write, combinational read, no reset (contents are don't-care).
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DEPTH = 14,
  parameter int WIDTH = 64,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/pool2x2_window_gen.sv
// Raster-order pixel stream to parallel 2x2 stride-2 windows for max-pool.
// Optional SOF_SYNC_EN adds pix_sof realignment and a sof_err strobe.
module pool2x2_window_gen
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = pool_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
`ifdef SOF_SYNC_EN
  input  logic                  pix_sof,
  output logic                  sof_err,
`endif
  output logic [DATA_WIDTH-1:0] win_tl,
  output logic [DATA_WIDTH-1:0] win_tr,
  output logic [DATA_WIDTH-1:0] win_bl,
  output logic [DATA_WIDTH-1:0] win_br,
  output logic                  win_valid,
  output logic                  frame_done
);
  localparam int CW    = cnt_width(IMG_WIDTH);
  localparam int RW    = cnt_width(IMG_HEIGHT);
  localparam int DEPTH = IMG_WIDTH / 2;
  localparam int AW    = cnt_width(DEPTH);

  logic [CW-1:0]           col_cnt, col, half;
  logic [RW-1:0]           row_cnt, row;
  logic [DATA_WIDTH-1:0]   hold;
  logic [2*DATA_WIDTH-1:0] rd_pair;
  logic                    wr_en, emit, col_last, row_last;

  // Effective position of the current pixel; SOF forces it to the origin.
  always_comb begin
    col = col_cnt;
    row = row_cnt;
`ifdef SOF_SYNC_EN
    if (pix_sof) begin
      col = '0;
      row = '0;
    end
`endif
  end

  assign half     = col >> 1;
  assign col_last = (col == CW'(IMG_WIDTH - 1));
  assign row_last = (row == RW'(IMG_HEIGHT - 1));
  assign wr_en    = pix_valid & ~row[0] & col[0];
  assign emit     = pix_valid &  row[0] & col[0];

  pool_line_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_WIDTH),
    .AW    (AW)
  ) u_lb (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (half[AW-1:0]),
    .wr_data ({hold, pix_in}),
    .rd_addr (half[AW-1:0]),
    .rd_data (rd_pair)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      hold       <= '0;
      win_tl     <= '0;
      win_tr     <= '0;
      win_bl     <= '0;
      win_br     <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= emit;
      frame_done <= pix_valid & col_last & row_last;
      if (pix_valid) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row + 1'b1;
        end else begin
          col_cnt <= col + 1'b1;
        end
        if (!col[0]) hold <= pix_in;
      end
      if (emit) begin
        win_tl <= rd_pair[2*DATA_WIDTH-1:DATA_WIDTH];
        win_tr <= rd_pair[DATA_WIDTH-1:0];
        win_bl <= hold;
        win_br <= pix_in;
      end
    end
  end

`ifdef SOF_SYNC_EN
  always_ff @(posedge clk) begin
    if (reset) sof_err <= 1'b0;
    else       sof_err <= pix_valid & pix_sof & ((col_cnt != '0) | (row_cnt != '0));
  end
`endif
endmodule
